// File: rtl/ubx_rx_parser_if.sv
// ---------------------------------------------------------------------------
// ubx_rx_parser_if
// Byte stream from the UART receiver into the UBX frame parser.
//   rx_data  8  received byte, meaningful only while rx_new is high
//   rx_new   1  one-cycle strobe per received byte
// Modports: master = UART receiver side (drives), slave = parser side.
// ---------------------------------------------------------------------------
interface ubx_rx_parser_if;
  logic [7:0] rx_data;
  logic       rx_new;

  modport master (output rx_data, output rx_new);
  modport slave  (input  rx_data, input  rx_new);
endinterface

// File: rtl/ubx_rx_parser.sv
// ---------------------------------------------------------------------------
// ubx_rx_parser
// Receive-side UBX frame parser. Consumes one byte per rx_new strobe, checks
// sync/class/id/length/Fletcher checksum and publishes NAV-POSLLH and
// NAV-VELNED fields. Outputs only change on a checksum-good known frame.
//
// Parameters
//   MAX_PAYLOAD   largest accepted payload length; longer frames are errors
//   IDLE_TIMEOUT  idle clk cycles allowed between bytes inside a frame
//
// Ports
//   clk, rst       clock; asynchronous active-high reset
//   rx             byte stream (ubx_rx_parser_if.slave)
//   long/lat/alt   NAV-POSLLH lon, lat, hMSL (signed, raw UBX units)
//   time_          iTOW of the last good POSLLH or VELNED frame
//   ground_speed   NAV-VELNED gSpeed (cm/s)
//   pos_valid      1-cycle pulse when long/lat/alt/time_ update
//   vel_valid      1-cycle pulse when ground_speed/time_ update
//   err_pulse      1-cycle pulse on checksum fail, oversize length, timeout
//   err_count      saturating error count
//
// Optional feature, macro UBX_ACK_EN: adds ack_valid/ack_nak/ack_cls/ack_id
// decoded from ACK-ACK / ACK-NAK frames. Without it, ACK frames are unknown.
// ---------------------------------------------------------------------------
module ubx_rx_parser #(
  parameter int MAX_PAYLOAD  = 64,
  parameter int IDLE_TIMEOUT = 100000
) (
  input  logic                clk,
  input  logic                rst,
  ubx_rx_parser_if.slave      rx,
  output logic [31:0]         long,
  output logic [31:0]         lat,
  output logic [31:0]         alt,
  output logic [31:0]         time_,
  output logic [31:0]         ground_speed,
  output logic                pos_valid,
  output logic                vel_valid,
  output logic                err_pulse,
  output logic [7:0]          err_count
`ifdef UBX_ACK_EN
  ,
  output logic                ack_valid,
  output logic                ack_nak,
  output logic [7:0]          ack_cls,
  output logic [7:0]          ack_id
`endif
);

  localparam int TW = $clog2(IDLE_TIMEOUT + 1);
  // Only the first 24 payload bytes carry fields we publish.
  localparam int SHADOW_BYTES = 24;

  typedef enum logic [3:0] {
    S_SYNC1, S_SYNC2, S_CLASS, S_ID, S_LEN_L, S_LEN_H, S_PAYLOAD, S_CK_A, S_CK_B
  } state_t;

  typedef enum logic [1:0] {K_NONE, K_POS, K_VEL, K_ACK} kind_t;

  state_t        state;
  kind_t         kind;
  logic [7:0]    cls;
  logic [7:0]    id;
  logic [7:0]    len_l;
  logic [15:0]   len;
  logic [15:0]   idx;
  logic [7:0]    ck_a;
  logic [7:0]    ck_b;
  logic          ck_a_bad;
  logic [TW-1:0] tmo_cnt;
  logic [7:0]    shadow [0:SHADOW_BYTES-1];

  logic [7:0]    byte_in;
  logic          byte_ok;
  logic [7:0]    ck_a_next;
  logic [7:0]    ck_b_next;
  logic [15:0]   len_next;
  kind_t         kind_next;
  logic          timeout;
  logic          ck_good;
  logic          err_now;

  logic [31:0]   sh_time, sh_lon, sh_lat, sh_alt, sh_gspd;

  assign byte_in = rx.rx_data;
  assign byte_ok = rx.rx_new;

  // Little-endian field views of the shadow bytes.
  assign sh_time = {shadow[3],  shadow[2],  shadow[1],  shadow[0]};
  assign sh_lon  = {shadow[7],  shadow[6],  shadow[5],  shadow[4]};
  assign sh_lat  = {shadow[11], shadow[10], shadow[9],  shadow[8]};
  assign sh_alt  = {shadow[19], shadow[18], shadow[17], shadow[16]};
  assign sh_gspd = {shadow[23], shadow[22], shadow[21], shadow[20]};

  // A byte arriving on the expiry cycle wins over the timeout.
  assign timeout = (state != S_SYNC1) && !byte_ok &&
                   (tmo_cnt == TW'(IDLE_TIMEOUT - 1));

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    ck_a_next = ck_a + byte_in;
    ck_b_next = ck_b + ck_a_next;
    len_next  = {byte_in, len_l};
    ck_good   = !ck_a_bad && (byte_in == ck_b);
    kind_next = K_NONE;
    if (cls == 8'h01 && id == 8'h02 && len_next == 16'd28)
      kind_next = K_POS;
    else if (cls == 8'h01 && id == 8'h12 && len_next == 16'd36)
      kind_next = K_VEL;
`ifdef UBX_ACK_EN
    else if (cls == 8'h05 && (id == 8'h00 || id == 8'h01) && len_next == 16'd2)
      kind_next = K_ACK;
`endif
    // Oversize and timeout both return to SYNC1, so a frame yields at most one error.
    err_now = timeout
           || (byte_ok && state == S_LEN_H && len_next > 16'(MAX_PAYLOAD))
           || (byte_ok && state == S_CK_B  && !ck_good);
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_SYNC1;
      kind         <= K_NONE;
      cls          <= '0;
      id           <= '0;
      len_l        <= '0;
      len          <= '0;
      idx          <= '0;
      ck_a         <= '0;
      ck_b         <= '0;
      ck_a_bad     <= 1'b0;
      tmo_cnt      <= '0;
      // NOTE: the shadow array is small and must read as zero after reset,
      // so it is reset like ordinary flops rather than left as a RAM.
      for (int i = 0; i < SHADOW_BYTES; i++) shadow[i] <= '0;
      long         <= '0;
      lat          <= '0;
      alt          <= '0;
      time_        <= '0;
      ground_speed <= '0;
      pos_valid    <= 1'b0;
      vel_valid    <= 1'b0;
      err_pulse    <= 1'b0;
      err_count    <= '0;
`ifdef UBX_ACK_EN
      ack_valid    <= 1'b0;
      ack_nak      <= 1'b0;
      ack_cls      <= '0;
      ack_id       <= '0;
`endif
    end else begin
      pos_valid <= 1'b0;
      vel_valid <= 1'b0;
      err_pulse <= 1'b0;
`ifdef UBX_ACK_EN
      ack_valid <= 1'b0;
`endif

      if (byte_ok || state == S_SYNC1) tmo_cnt <= '0;
      else                             tmo_cnt <= tmo_cnt + TW'(1);

      if (err_now) begin
        err_pulse <= 1'b1;
        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
      end

      if (timeout) begin
        state <= S_SYNC1;
      end else if (byte_ok) begin
        case (state)
          S_SYNC1: if (byte_in == 8'hB5) state <= S_SYNC2;
          S_SYNC2: begin
            if (byte_in == 8'h62) begin
              state <= S_CLASS;
              ck_a  <= '0;
              ck_b  <= '0;
            end else if (byte_in != 8'hB5) begin
              state <= S_SYNC1;
            end
          end
          S_CLASS: begin
            cls   <= byte_in;
            ck_a  <= ck_a_next;
            ck_b  <= ck_b_next;
            state <= S_ID;
          end
          S_ID: begin
            id    <= byte_in;
            ck_a  <= ck_a_next;
            ck_b  <= ck_b_next;
            state <= S_LEN_L;
          end
          S_LEN_L: begin
            len_l <= byte_in;
            ck_a  <= ck_a_next;
            ck_b  <= ck_b_next;
            state <= S_LEN_H;
          end
          S_LEN_H: begin
            len   <= len_next;
            kind  <= kind_next;
            idx   <= '0;
            ck_a  <= ck_a_next;
            ck_b  <= ck_b_next;
            if (len_next > 16'(MAX_PAYLOAD)) state <= S_SYNC1;
            else if (len_next == 16'd0)      state <= S_CK_A;
            else                             state <= S_PAYLOAD;
          end
          S_PAYLOAD: begin
            ck_a <= ck_a_next;
            ck_b <= ck_b_next;
            if (kind != K_NONE && idx < 16'(SHADOW_BYTES))
              shadow[idx[4:0]] <= byte_in;
            idx <= idx + 16'd1;
            if (idx == len - 16'd1) state <= S_CK_A;
          end
          S_CK_A: begin
            // Mismatch is remembered and reported together with CK_B.
            ck_a_bad <= (byte_in != ck_a);
            state    <= S_CK_B;
          end
          S_CK_B: begin
            state <= S_SYNC1;
            if (ck_good) begin
              case (kind)
                K_POS: begin
                  long      <= sh_lon;
                  lat       <= sh_lat;
                  alt       <= sh_alt;
                  time_     <= sh_time;
                  pos_valid <= 1'b1;
                end
                K_VEL: begin
                  ground_speed <= sh_gspd;
                  time_        <= sh_time;
                  vel_valid    <= 1'b1;
                end
`ifdef UBX_ACK_EN
                K_ACK: begin
                  ack_cls   <= shadow[0];
                  ack_id    <= shadow[1];
                  ack_nak   <= (id == 8'h00);
                  ack_valid <= 1'b1;
                end
`endif
                default: ;
              endcase
            end
          end
          default: state <= S_SYNC1;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ubx_rx_parser.sv
// ---------------------------------------------------------------------------
// tb_ubx_rx_parser
// Self-checking bench for ubx_rx_parser. Frames are built and checksummed by
// the bench; each frame that must produce a pulse pushes an expected snapshot
// (pulse kind, cycle, all output values) onto a scoreboard, and a monitor on
// the falling edge pops and compares whenever the DUT pulses.
// Honours UBX_ACK_EN for the optional ACK outputs.
// ---------------------------------------------------------------------------
module tb_ubx_rx_parser;

  localparam int T_IDLE = 200;

  typedef logic [7:0] byte_t;
  typedef byte_t bq_t[$];
  typedef enum int {EV_NONE, EV_POS, EV_VEL, EV_ERR, EV_ACK, EV_NAK} ev_e;

  typedef struct {
    logic [3:0]  code;
    int          cyc;
    logic [31:0] lon, lat, alt, tim, gs;
    logic [7:0]  errc;
    logic        ack_nak;
    logic [7:0]  ack_cls, ack_id;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] long, lat, alt, time_, ground_speed;
  logic        pos_valid, vel_valid, err_pulse;
  logic [7:0]  err_count;
  logic        ack_v;
`ifdef UBX_ACK_EN
  logic        ack_valid, ack_nak;
  logic [7:0]  ack_cls, ack_id;
  assign ack_v = ack_valid;
`else
  assign ack_v = 1'b0;
`endif

  ubx_rx_parser_if rx_if ();

  ubx_rx_parser #(.MAX_PAYLOAD(64), .IDLE_TIMEOUT(T_IDLE)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx           (rx_if.slave),
    .long         (long),
    .lat          (lat),
    .alt          (alt),
    .time_        (time_),
    .ground_speed (ground_speed),
    .pos_valid    (pos_valid),
    .vel_valid    (vel_valid),
    .err_pulse    (err_pulse),
    .err_count    (err_count)
`ifdef UBX_ACK_EN
    ,
    .ack_valid    (ack_valid),
    .ack_nak      (ack_nak),
    .ack_cls      (ack_cls),
    .ack_id       (ack_id)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int    checks = 0;
  int    errors = 0;
  int    drive_cyc = 0;
  exp_t  sb[$];
  exp_t  mon_e;

  logic [31:0] m_lon, m_lat, m_alt, m_tim, m_gs;
  logic [7:0]  m_errc, m_ack_cls, m_ack_id;
  logic        m_ack_nak;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bq_t filler(input int n, input int seed);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(8'((i * 13 + seed) & 255));
    return q;
  endfunction

  function automatic bq_t put32(input bq_t q, input int o, input logic [31:0] v);
    bq_t r;
    r = q;
    for (int i = 0; i < 4; i++) r[o + i] = v[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] le32(input bq_t q, input int o);
    return {q[o + 3], q[o + 2], q[o + 1], q[o]};
  endfunction

  function automatic bq_t make_pos(input logic [31:0] itow, lon, latv, hmsl);
    bq_t q;
    q = filler(28, 3);
    q = put32(q, 0, itow);
    q = put32(q, 4, lon);
    q = put32(q, 8, latv);
    q = put32(q, 16, hmsl);
    return q;
  endfunction

  function automatic bq_t make_vel(input logic [31:0] itow, gspd);
    bq_t q;
    q = filler(36, 7);
    q = put32(q, 0, itow);
    q = put32(q, 20, gspd);
    return q;
  endfunction

  task automatic drive_byte(input byte_t b);
    @(negedge clk);
    rx_if.rx_data = b;
    rx_if.rx_new  = 1'b1;
    drive_cyc     = cyc;
  endtask

  task automatic release_byte();
    @(negedge clk);
    rx_if.rx_new = 1'b0;
  endtask

  task automatic send_byte(input byte_t b);
    drive_byte(b);
    release_byte();
  endtask

  // Update the reference output state and queue the pulse expected at 'at'.
  task automatic expect_evt(input ev_e ev, input bq_t pl, input int at);
    exp_t e;
    case (ev)
      EV_POS: begin
        m_tim = le32(pl, 0);
        m_lon = le32(pl, 4);
        m_lat = le32(pl, 8);
        m_alt = le32(pl, 16);
      end
      EV_VEL: begin
        m_tim = le32(pl, 0);
        m_gs  = le32(pl, 20);
      end
      EV_ERR: if (m_errc != 8'hFF) m_errc = m_errc + 8'd1;
      EV_ACK, EV_NAK: begin
        m_ack_cls = pl[0];
        m_ack_id  = pl[1];
        m_ack_nak = (ev == EV_NAK);
      end
      default: ;
    endcase
    e.code    = (ev == EV_POS) ? 4'd1 : (ev == EV_VEL) ? 4'd2 : (ev == EV_ERR) ? 4'd4 : 4'd8;
    e.cyc     = at;
    e.lon     = m_lon;
    e.lat     = m_lat;
    e.alt     = m_alt;
    e.tim     = m_tim;
    e.gs      = m_gs;
    e.errc    = m_errc;
    e.ack_nak = m_ack_nak;
    e.ack_cls = m_ack_cls;
    e.ack_id  = m_ack_id;
    sb.push_back(e);
  endtask

  task automatic send_frame(input byte_t cls, input byte_t id, input bq_t pl,
                            input byte_t ckb_xor, input ev_e ev);
    bq_t   body;
    byte_t a, b;
    int    n;
    n = pl.size();
    body.push_back(cls);
    body.push_back(id);
    body.push_back(8'(n & 255));
    body.push_back(8'((n >> 8) & 255));
    foreach (pl[i]) body.push_back(pl[i]);
    a = 8'd0;
    b = 8'd0;
    foreach (body[i]) begin
      a = a + body[i];
      b = b + a;
    end
    send_byte(8'hB5);
    send_byte(8'h62);
    foreach (body[i]) send_byte(body[i]);
    send_byte(a);
    drive_byte(b ^ ckb_xor);
    if (ev != EV_NONE) expect_evt(ev, pl, drive_cyc + 1);
    release_byte();
  endtask

  // Header with an oversize length: error is due right after LEN_H.
  task automatic send_oversize(input logic [15:0] len);
    bq_t none;
    send_byte(8'hB5);
    send_byte(8'h62);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(len[7:0]);
    drive_byte(len[15:8]);
    expect_evt(EV_ERR, none, drive_cyc + 1);
    release_byte();
  endtask

  task automatic drain();
    for (int i = 0; i < 2000 && sb.size() != 0; i++) @(negedge clk);
    check("scoreboard_drain", sb.size(), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_long"}, long, 0);
    check({tag, "_lat"}, lat, 0);
    check({tag, "_alt"}, alt, 0);
    check({tag, "_time"}, time_, 0);
    check({tag, "_gspeed"}, ground_speed, 0);
    check({tag, "_pulses"}, {28'd0, ack_v, err_pulse, vel_valid, pos_valid}, 0);
    check({tag, "_err_count"}, {24'd0, err_count}, 0);
`ifdef UBX_ACK_EN
    check({tag, "_ack"}, {15'd0, ack_nak, ack_cls, ack_id}, 0);
`endif
  endtask

  // Scoreboard consumer: every output pulse must match the next expectation.
  always @(negedge clk) begin
    if (!rst && (pos_valid || vel_valid || err_pulse || ack_v)) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", {28'd0, ack_v, err_pulse, vel_valid, pos_valid}, 0);
      end else begin
        mon_e = sb.pop_front();
        check("pulse_kind", {28'd0, ack_v, err_pulse, vel_valid, pos_valid}, {28'd0, mon_e.code});
        check("pulse_cycle", cyc, mon_e.cyc);
        check("long", long, mon_e.lon);
        check("lat", lat, mon_e.lat);
        check("alt", alt, mon_e.alt);
        check("time_", time_, mon_e.tim);
        check("ground_speed", ground_speed, mon_e.gs);
        check("err_count", {24'd0, err_count}, {24'd0, mon_e.errc});
`ifdef UBX_ACK_EN
        check("ack_fields", {15'd0, ack_nak, ack_cls, ack_id},
              {15'd0, mon_e.ack_nak, mon_e.ack_cls, mon_e.ack_id});
`endif
      end
    end
  end

  initial begin
    bq_t pos1, pos2, pos3, vel1, vel2, none, ackp;

    rst = 1'b1;
    rx_if.rx_data = 8'h00;
    rx_if.rx_new  = 1'b0;
    m_lon = 0; m_lat = 0; m_alt = 0; m_tim = 0; m_gs = 0;
    m_errc = 0; m_ack_cls = 0; m_ack_id = 0; m_ack_nak = 0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Test 1: POSLLH commit
    pos1 = make_pos(32'h0000_1000, 32'h0A1B_2C3D, 32'hF123_4567, 32'h0000_C350);
    send_frame(8'h01, 8'h02, pos1, 8'h00, EV_POS);
    drain();
    check("t1_alt_decimal", alt, 32'd50000);

    // Test 2: VELNED, position fields must hold
    vel1 = make_vel(32'h0000_2000, 32'd1234);
    send_frame(8'h01, 8'h12, vel1, 8'h00, EV_VEL);

    // Test 3: corrupted CK_B
    send_frame(8'h01, 8'h02, pos1, 8'h01, EV_ERR);
    drain();
    check("t3_err_count", {24'd0, err_count}, 32'd1);

    // Test 4: B5 B5 62 resync, then oversize length, then a frame from SYNC1
    send_byte(8'hB5);
    pos2 = make_pos(32'h0000_3000, 32'h8000_0001, 32'h1234_5678, 32'hFFFF_FF00);
    send_frame(8'h01, 8'h02, pos2, 8'h00, EV_POS);
    send_oversize(16'h0100);
    vel2 = make_vel(32'h0000_4000, 32'hDEAD_0042);
    send_frame(8'h01, 8'h12, vel2, 8'h00, EV_VEL);

    // Boundaries: unknown len 0, unknown len == MAX_PAYLOAD, known id with
    // wrong length, and len == MAX_PAYLOAD+1
    send_frame(8'h0A, 8'h04, none, 8'h00, EV_NONE);
    send_frame(8'h02, 8'h15, filler(64, 1), 8'h00, EV_NONE);
    send_frame(8'h01, 8'h02, filler(20, 9), 8'h00, EV_NONE);
    send_oversize(16'd65);

    // ACK-NAK: decoded only with the feature enabled
    ackp.push_back(8'h06);
    ackp.push_back(8'h24);
`ifdef UBX_ACK_EN
    send_frame(8'h05, 8'h00, ackp, 8'h00, EV_NAK);
`else
    send_frame(8'h05, 8'h00, ackp, 8'h00, EV_NONE);
`endif
    drain();

    // Test 5: stall mid-payload until timeout, then a good frame
    send_byte(8'hB5);
    send_byte(8'h62);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h1C);
    send_byte(8'h00);
    for (int i = 0; i < 5; i++) send_byte(pos1[i]);
    expect_evt(EV_ERR, none, drive_cyc + 1 + T_IDLE);
    repeat (T_IDLE + 5) @(negedge clk);
    pos3 = make_pos(32'h0000_5000, 32'h0000_0007, 32'h0000_0009, 32'h0000_000B);
    send_frame(8'h01, 8'h02, pos3, 8'h00, EV_POS);

    // 300 bad frames saturate err_count
    for (int i = 0; i < 300; i++) send_frame(8'h0A, 8'h04, none, 8'hFF, EV_ERR);
    drain();
    check("err_count_saturated", {24'd0, err_count}, 32'd255);

    // Reset mid-frame clears everything and discards the partial frame
    send_byte(8'hB5);
    send_byte(8'h62);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h1C);
    send_byte(8'h00);
    for (int i = 0; i < 6; i++) send_byte(pos2[i]);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("midframe_reset");
    m_lon = 0; m_lat = 0; m_alt = 0; m_tim = 0; m_gs = 0;
    m_errc = 0; m_ack_cls = 0; m_ack_id = 0; m_ack_nak = 0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    send_frame(8'h01, 8'h02, pos1, 8'h00, EV_POS);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
